vga_sync_ctrl: RTL

//  Timing generator and sequencer for the VGA pixel path. Runs horizontal and vertical

---
 rtl/vga_sync_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/vga_sync_ctrl.sv
// VGA timing generator: h/v counters, registered sync/visible-pixel decode,
// and a start/stop sequencer that only stops or starts on frame boundaries.
module vga_sync_ctrl #(
    parameter int H_SYNC  = 120,
    parameter int H_BACK  = 64,
    parameter int H_ACT   = 800,
    parameter int H_FRONT = 56,
    parameter int V_SYNC  = 6,
    parameter int V_BACK  = 23,
    parameter int V_ACT   = 600,
    parameter int V_FRONT = 37
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        hsync,
    output logic        vsync,
    output logic        ready,
    output logic [10:0] x_addr,
    output logic [10:0] y_addr,
    output logic        frame_start,
    output logic        busy
);
    localparam logic [10:0] H_SYNC_C = 11'(H_SYNC);
    localparam logic [10:0] H_ACT_LO = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_HI = 11'(H_SYNC + H_BACK + H_ACT);
    localparam logic [10:0] H_LAST   = 11'(H_SYNC + H_BACK + H_ACT + H_FRONT - 1);
    localparam logic [10:0] V_SYNC_C = 11'(V_SYNC);
    localparam logic [10:0] V_ACT_LO = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_ACT_HI = 11'(V_SYNC + V_BACK + V_ACT);
    localparam logic [10:0] V_LAST   = 11'(V_SYNC + V_BACK + V_ACT + V_FRONT - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;

    state_t      state, state_nxt;
    logic [10:0] h_cnt, v_cnt;
    logic        h_last, v_last, frame_last, visible;

    assign h_last     = (h_cnt == H_LAST);
    assign v_last     = (v_cnt == V_LAST);
    assign frame_last = h_last && v_last;
    assign visible    = (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI) &&
                        (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);

    // Frame end wins over a re-enable in STOP_PEND, giving one idle clock.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (en) state_nxt = RUN;
            RUN:       if (!en) state_nxt = STOP_PEND;
            STOP_PEND: begin
                if (frame_last)  state_nxt = IDLE;
                else if (en)     state_nxt = RUN;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Counters wrap to 0 at frame end, so IDLE is always entered with them cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state != IDLE) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            ready       <= 1'b0;
            x_addr      <= '0;
            y_addr      <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            hsync       <= (h_cnt >= H_SYNC_C);
            vsync       <= (v_cnt >= V_SYNC_C);
            ready       <= visible;
            x_addr      <= visible ? h_cnt - H_ACT_LO : 11'd0;
            y_addr      <= visible ? v_cnt - V_ACT_LO : 11'd0;
            frame_start <= (state == RUN) && (h_cnt == 11'd0) && (v_cnt == 11'd0);
            busy        <= 1'b1;
        end
    end
endmodule
